// File: rtl/eva_ahb_timer_regs.sv
// eva_ahb_timer_regs: AHB-lite slave with ID/scratch registers, a down-counting timer,
// W1C timeout status, level irq and programmable wait-state insertion.
module eva_ahb_timer_regs #(
  parameter logic [31:0] ID_VALUE = 32'hEA7A_0001,
  parameter int          ADDR_W   = 8
) (
  input  logic              hclk,
  input  logic              hrest_n,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hsize,
  input  logic [31:0]       hwdata,
  input  logic              hready,
  output logic              hready_out,
  output logic [1:0]        hresp,
  output logic [31:0]       hrdata,
  output logic              irq
);
  typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;
  state_t state, state_nx;
  logic [2:0] a_idx;
  logic a_wr;
  logic [3:0] wcnt;
  logic [31:0] scratch, load, count, rd;
  logic [2:0] ctrl;
  logic stat;
  logic [3:0] wait_cfg;
  logic acc, bad, wr, timeout;
  assign acc = hsel & hready & (htrans == 2'b10 | htrans == 2'b11);
  // Misaligned byte offsets are treated as undecoded offsets.
  assign bad = (hsize != 3'b010) | (haddr[1:0] != 2'b00) | (haddr[ADDR_W-1:2] > (ADDR_W-2)'(6));
  assign wr = (state == DONE) & a_wr;
  assign timeout = ctrl[0] & (count == '0);
  always_ff @(posedge hclk or negedge hrest_n)
    if (!hrest_n) state <= IDLE;
    else state <= state_nx;
  // WAIT_CFG is sampled at address acceptance, so a write to it only affects later transfers.
  always_comb
    state_nx = acc ? (bad ? ERR1 : (wait_cfg != 4'd0 ? WAIT : DONE)) :
               state == WAIT ? (wcnt == 4'd1 ? DONE : WAIT) :
               state == ERR1 ? ERR2 : IDLE;
  always_comb begin
    case (a_idx)
      3'd0:    rd = ID_VALUE;
      3'd1:    rd = scratch;
      3'd2:    rd = {29'd0, ctrl};
      3'd3:    rd = load;
      3'd4:    rd = count;
      3'd5:    rd = {31'd0, stat};
      3'd6:    rd = {28'd0, wait_cfg};
      default: rd = '0;
    endcase
  end
  always_comb begin
    hready_out = !(state == WAIT || state == ERR1);
    hresp = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
    hrdata = (state == DONE && !a_wr) ? rd : '0;
  end
  always_ff @(posedge hclk or negedge hrest_n) begin
    if (!hrest_n) begin
      a_idx <= '0;
      a_wr <= 1'b0;
      wcnt <= '0;
    end else if (acc) begin
      a_idx <= haddr[4:2];
      a_wr <= hwrite;
      wcnt <= wait_cfg;
    end else if (state == WAIT) wcnt <= wcnt - 4'd1;
  end
  // A bus write wins over the timer for LOAD/COUNT and CTRL; a timeout wins over a W1C clear.
  always_ff @(posedge hclk or negedge hrest_n) begin
    if (!hrest_n) begin
      scratch <= '0;
      ctrl <= '0;
      load <= '0;
      count <= '0;
      stat <= 1'b0;
      wait_cfg <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && a_idx == 3'd1) scratch <= hwdata;
      if (wr && a_idx == 3'd2) ctrl <= hwdata[2:0];
      else if (timeout && !ctrl[1]) ctrl[0] <= 1'b0;
      if (wr && a_idx == 3'd3) begin
        load <= hwdata;
        count <= hwdata;
      end else if (ctrl[0]) count <= (count != '0) ? count - 32'd1 : (ctrl[1] ? load : '0);
      if (timeout) stat <= 1'b1;
      else if (wr && a_idx == 3'd5 && hwdata[0]) stat <= 1'b0;
      if (wr && a_idx == 3'd6) wait_cfg <= hwdata[3:0];
      irq <= stat & ctrl[2];
    end
  end
endmodule
